mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Bus master for the picorv32-style native memory interface. It drives mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_instr and the look-ahead mem_la_* strobes, and consumes mem_ready/mem_rdata from a memory responder.
- Accepts one word request at a time from a simple valid/ready request port and returns read data or a status on a valid/ready response port.
- Used as a testbench/DMA-style traffic source wherever a non-CPU agent must access memory through the native interface.

Parameters:
- TIMEOUT_CYCLES, 64, maximum ACCESS cycles waiting for mem_ready before an error response; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_instr  in  1  marks an instruction fetch; forwarded to mem_instr
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  byte enables for writes; ignored for reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_error  out  1  timeout, or an illegal request
- mem_valid  out  1  native bus request
- mem_instr  out  1  native instruction flag
- mem_ready  in  1  responder handshake
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  0 for reads
- mem_rdata  in  32  read data
- mem_la_read  out  1  look-ahead read strobe, combinational
- mem_la_write  out  1  look-ahead write strobe, combinational
- mem_la_addr  out  32  look-ahead address, combinational
- mem_la_wdata  out  32  look-ahead write data
- mem_la_wstrb  out  4  look-ahead byte enables

Behaviour:
- Reset values: state IDLE; req_ready=0 during reset; rsp_valid=0, rsp_rdata=0, rsp_error=0; mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0; timeout counter=0. All mem_la_* outputs are 0 while reset is high.
- State machine:
  - IDLE -> ACCESS on accept.
  - IDLE -> RESP on accept of an illegal request (see Optional Feature).
  - ACCESS -> RESP on mem_ready or on timeout.
  - RESP -> IDLE when rsp_ready is high.
- req_ready = (state==IDLE) && !reset. Accept = req_valid && req_ready.
- Look-ahead in the accept cycle, combinational from the request:
  - mem_la_read = !req_write.
  - mem_la_write = req_write.
  - mem_la_addr = {req_addr[31:2],2'b00}.
  - mem_la_wdata = req_wdata; mem_la_wstrb = req_write ? req_wstrb : 0.
  - All mem_la_* are 0 in every other cycle.
- On accept, register into the mem_* outputs: mem_addr = aligned address, mem_wdata, mem_wstrb (0 for reads), mem_instr. mem_valid=1 from the next cycle.
- ACCESS:
  - mem_valid held high; mem_* fields stable.
  - Counter increments every cycle that mem_ready=0.
  - On the edge where mem_ready=1: mem_valid<=0; rsp_rdata<=mem_rdata for reads, 0 for writes; rsp_error<=0; rsp_valid<=1.
- Latency: with mem_ready high in the first ACCESS cycle, rsp_valid rises 2 cycles after accept.
- Timeout: if the counter reaches TIMEOUT_CYCLES (nonzero) with mem_ready still 0, then mem_valid<=0, rsp_error<=1, rsp_rdata<=0.
  - If mem_ready=1 in the same cycle as the counter reaching the limit, mem_ready wins and no error is reported.
- RESP:
  - rsp_valid, rsp_rdata and rsp_error are held until rsp_ready=1.
  - On that edge rsp_valid<=0, the counter clears, and the state returns to IDLE.
  - req_ready is high in the following cycle, so back-to-back throughput is 1 request per 3 cycles minimum.
- Write with req_wstrb=0: issued as a normal bus write with mem_wstrb=0 and mem_la_write=1; no error.
- mem_ready asserted outside ACCESS is ignored.
- Reset asserted in any state: on that edge, return to IDLE and force all outputs to their reset values. An in-flight bus access is abandoned and no response is produced.

Optional Feature:
- Macro: MEM_INITIATOR_ALIGN_CHECK_EN.
- Defined:
  - A request with req_addr[1:0]!=0 is accepted but not issued on the bus.
  - mem_valid and all mem_la_* stay 0.
  - The state goes directly to RESP with rsp_error=1 and rsp_rdata=0; rsp_valid rises 1 cycle after accept.
- Undefined: the low address bits are silently cleared and the access proceeds normally.

Test Plan:
- Reset for 3 cycles, then release -> all outputs 0 during reset; req_ready=1 in the first cycle after release.
- Write 0xDEADBEEF to 0x100 with wstrb 0xF, then read 0x100 against a zero-wait responder:
  - Write accept cycle: mem_la_write=1, mem_la_addr=0x100.
  - Read: rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_error=0.
- Write 0x000000AA to 0x104 with wstrb 0x1 over a word previously holding 0x11223344 -> a subsequent read returns 0x112233AA.
- Responder holds mem_ready=0, TIMEOUT_CYCLES=4 -> mem_valid high for exactly 4 cycles, then rsp_error=1, rsp_rdata=0.
- rsp_ready held 0 for 5 cycles after a read of 0x100 -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout; IDLE reached the cycle after rsp_ready=1.
- Read of 0x102:
  - Macro defined: no bus activity, rsp_error=1 one cycle after accept.
  - Macro undefined: mem_addr=0x100, rsp_error=0.

Source files
------------

// File: rtl/mem_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_initiator: single-outstanding bus master for the native memory bus.  |
// | Optional: MEM_INITIATOR_ALIGN_CHECK_EN rejects misaligned addresses.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_initiator #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_instr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        mem_la_read,
    output logic        mem_la_write,
    output logic [31:0] mem_la_addr,
    output logic [31:0] mem_la_wdata,
    output logic [3:0]  mem_la_wstrb
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_TIMEOUT    = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0]      c_WORD_MASK  = 32'hFFFF_FFFC;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_write;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_error;
    logic             r_mem_valid;
    logic             r_mem_instr;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_wstrb;
    logic             w_accept;
    logic             w_misaligned;
    logic             w_issue;
    logic             w_in_access;
    logic             w_timeout;

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
    assign w_misaligned = (req_addr[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_issue     = w_accept && !w_misaligned;
    assign w_in_access = (r_state == S_ACCESS);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    // The limit is hit on the edge the counter would reach it; a same-cycle mem_ready still wins.
    assign w_timeout   = c_TIMEOUT_EN && w_in_access && !mem_ready && (w_cnt_inc == c_TIMEOUT);

    assign mem_la_read  = w_issue && !req_write;
    assign mem_la_write = w_issue && req_write;
    assign mem_la_addr  = w_issue ? (req_addr & c_WORD_MASK) : 32'h0;
    assign mem_la_wdata = w_issue ? req_wdata : 32'h0;
    assign mem_la_wstrb = (w_issue && req_write) ? req_wstrb : 4'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_misaligned ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ready || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_error <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_instr <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
        end else begin
            if (w_issue) begin
                r_mem_valid <= 1'b1;
                r_mem_instr <= req_instr;
                r_mem_addr  <= req_addr & c_WORD_MASK;
                r_mem_wdata <= req_wdata;
                r_mem_wstrb <= req_write ? req_wstrb : 4'h0;
                r_write     <= req_write;
            end
            if (w_accept && w_misaligned) begin
                r_rsp_valid <= 1'b1;
                r_rsp_error <= 1'b1;
                r_rsp_rdata <= 32'h0;
            end
            if (w_in_access) begin
                if (mem_ready) begin
                    r_mem_valid <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= 1'b0;
                    r_rsp_rdata <= r_write ? 32'h0 : mem_rdata;
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                    end
                end
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_cnt       <= '0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign mem_valid = r_mem_valid;
    assign mem_instr = r_mem_instr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_initiator: table vectors, hand sequences and random traffic       |
// | against a word-array reference model. Revision: 1.0                      |
// +--------------------------------------------------------------------------+
module tb_mem_initiator;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_instr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_la_read, mem_la_write;
    logic [31:0] mem_la_addr, mem_la_wdata;
    logic [3:0]  mem_la_wstrb;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_instr(req_instr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_la_read(mem_la_read), .mem_la_write(mem_la_write),
        .mem_la_addr(mem_la_addr), .mem_la_wdata(mem_la_wdata),
        .mem_la_wstrb(mem_la_wstrb)
    );

    // Responder: ready after rsp_wait_target stalled cycles; 'stray' pulses ready at any time.
    logic [31:0] smem [0:255];
    int unsigned rsp_wait_target = 0;
    int unsigned wcnt = 0;
    logic        stray = 1'b0;

    assign mem_ready = (mem_valid && (wcnt >= rsp_wait_target)) || stray;
    assign mem_rdata = smem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) smem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            wcnt <= 0;
        end else if (mem_valid) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    logic [31:0] ref_mem [0:255];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what the bus and response should look like for one request.
    task automatic model_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] ws, input int wt,
                             output logic [31:0] e_rd, output logic e_err,
                             output int e_lat, output int e_mv);
        logic mis;
        int   i;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        i = int'(addr[9:2]);
        if (mis) begin
            e_rd = 0; e_err = 1; e_lat = 1; e_mv = 0;
        end else if (wt >= TO) begin
            e_rd = 0; e_err = 1; e_lat = TO + 1; e_mv = TO;
        end else begin
            e_rd  = wr ? 32'h0 : ref_mem[i];
            e_err = 0; e_lat = wt + 2; e_mv = wt + 1;
            if (wr)
                for (int b = 0; b < 4; b++)
                    if (ws[b]) ref_mem[i][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic do_txn(input logic wr, input logic ins, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws, input int wt,
                          input int dly, input logic [31:0] e_rd, input logic e_err,
                          input int e_lat, input int e_mv);
        logic        bus;
        logic [31:0] a_al;
        int          lat, mvc;
        bus  = (e_mv != 0);
        a_al = {addr[31:2], 2'b00};
        rsp_wait_target = wt;
        @(negedge clk);
        req_valid = 1; req_write = wr; req_instr = ins; req_addr = addr;
        req_wdata = wd; req_wstrb = ws; rsp_ready = 0;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        chk("la_read",  32'(mem_la_read),  32'(bus && !wr));
        chk("la_write", 32'(mem_la_write), 32'(bus && wr));
        chk("la_addr",  mem_la_addr,  bus ? a_al : 32'h0);
        chk("la_wdata", mem_la_wdata, bus ? wd : 32'h0);
        chk("la_wstrb", 32'(mem_la_wstrb), 32'((bus && wr) ? ws : 4'h0));
        @(posedge clk);
        #1;
        req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        lat = 0; mvc = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1)
                chk("la_idle_after_accept", 32'({mem_la_read, mem_la_write, |mem_la_addr}), 32'd0);
            if (mem_valid) begin
                mvc++;
                if (mvc == 1) begin
                    chk("mem_addr", mem_addr, a_al);
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(wr ? ws : 4'h0));
                    chk("mem_instr", 32'(mem_instr), 32'(ins));
                    if (wr) chk("mem_wdata", mem_wdata, wd);
                end
            end
            if (rsp_valid) break;
            if (lat > 30) begin
                chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
                break;
            end
        end
        chk("rsp_latency", lat, e_lat);
        chk("mem_valid_cycles", mvc, e_mv);
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_error", 32'(rsp_error), 32'(e_err));
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, e_rd);
            chk("hold_rsp_error", 32'(rsp_error), 32'(e_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
        chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic        ins;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          wt;
        int          dly;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] m_rd;
        logic        m_err;
        int          m_lat, m_mv;
        logic        w;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          wt;

        for (int i = 0; i < 256; i++) begin smem[i] = 0; ref_mem[i] = 0; end
        reset = 1; req_valid = 1; req_write = 1; req_instr = 1;
        req_addr = 32'h104; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF; rsp_ready = 0;

        // Reset: even with a request presented every output must stay 0.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs_zero", 32'(|{req_ready, rsp_valid, rsp_rdata, rsp_error,
                mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mem_la_read,
                mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb}), 32'd0);
        end
        req_valid = 0; reset = 0;
        #1;
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);

        vecs[0]  = '{1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        1'b0, 2};
        vecs[1]  = '{1'b0, 1'b0, 32'h100, 32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 1'b0, 2};
        vecs[2]  = '{1'b1, 1'b0, 32'h104, 32'h11223344, 4'hF, 1, 0, 32'h0,        1'b0, 3};
        vecs[3]  = '{1'b1, 1'b0, 32'h104, 32'h000000AA, 4'h1, 0, 0, 32'h0,        1'b0, 2};
        vecs[4]  = '{1'b0, 1'b1, 32'h104, 32'h0,        4'h0, 2, 1, 32'h112233AA, 1'b0, 4};
        vecs[5]  = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 4, 0, 32'h0,        1'b1, 5};
        vecs[6]  = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 3, 0, 32'hDEADBEEF, 1'b0, 5};
        vecs[7]  = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 0, 5, 32'hDEADBEEF, 1'b0, 2};
        vecs[8]  = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 0, 0, 32'h0,        1'b0, 2};
        vecs[9]  = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 1'b0, 2};
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
        vecs[10] = '{1'b0, 1'b0, 32'h102, 32'h0,        4'h0, 0, 0, 32'h0,        1'b1, 1};
`else
        vecs[10] = '{1'b0, 1'b0, 32'h102, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 1'b0, 2};
`endif
        vecs[11] = '{1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, 4'hF, 6, 0, 32'h0,        1'b1, 5};
        vecs[12] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 1'b0, 2};

        for (int v = 0; v < 13; v++) begin
            model_txn(vecs[v].wr, vecs[v].addr, vecs[v].wd, vecs[v].ws, vecs[v].wt,
                      m_rd, m_err, m_lat, m_mv);
            do_txn(vecs[v].wr, vecs[v].ins, vecs[v].addr, vecs[v].wd, vecs[v].ws,
                   vecs[v].wt, vecs[v].dly, vecs[v].e_rd, vecs[v].e_err, vecs[v].e_lat, m_mv);
        end

        // mem_ready while idle must not create a response.
        @(negedge clk);
        stray = 1;
        repeat (2) begin
            @(negedge clk);
            chk("stray_ready_no_rsp", 32'({rsp_valid, mem_valid}), 32'd0);
            chk("stray_ready_req_ready", 32'(req_ready), 32'd1);
        end
        stray = 0;

        // Reset during a stalled access abandons it without a response.
        rsp_wait_target = 1000;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h108;
        @(posedge clk);
        #1 req_valid = 0;
        repeat (2) @(negedge clk);
        chk("inflight_mem_valid", 32'(mem_valid), 32'd1);
        reset = 1;
        @(negedge clk);
        chk("midreset_outputs_zero", 32'(|{req_ready, rsp_valid, rsp_rdata, rsp_error,
            mem_valid, mem_addr, mem_wstrb, mem_la_read, mem_la_write, mem_la_addr}), 32'd0);
        reset = 0;
        #1;
        chk("req_ready_after_midreset", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("no_rsp_after_abandon", 32'({rsp_valid, mem_valid}), 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            w  = 1'($urandom);
            a  = 32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
            d  = $urandom;
            s  = 4'($urandom);
            wt = $urandom_range(0, 5);
            model_txn(w, a, d, s, wt, m_rd, m_err, m_lat, m_mv);
            do_txn(w, 1'($urandom), a, d, s, wt, $urandom_range(0, 2), m_rd, m_err, m_lat, m_mv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
